// File: rtl/fetch_ctl.sv
// fetch_ctl: sequencing controller for the 16-bit PC / instruction-fetch stage.
// Each cycle it decides the PC write enable, IF/ID hold/flush and ID/EX bubble.
// It arbitrates imem wait, load-use stall, dmem freeze, branch, jump and HALT,
// drops in-flight fetches after a redirect and drains the pipe on HALT.
//
// Optional feature macro: FETCH_CTL_PERF_EN (stall cycle counter on stall_cnt).
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   imem_done           instruction memory returned a valid word this cycle
//   hazard_stall        load-use hazard in ID
//   dmem_stall          data memory busy, freezes whole pipe
//   br_ctl              conditional branch taken (EX)
//   jump                jump in ID
//   halt_dec            HALT decoded in ID
//   pc_en               PC register write enable
//   imem_req            fetch request at current PC
//   if_id_en            IF/ID write enable
//   if_id_flush         load NOP into IF/ID
//   id_ex_flush         load NOP into ID/EX
//   pipe_freeze         hold all pipeline registers
//   halted              sticky, processor stopped
//   err                 sticky, imem timeout
//   stall_cnt           stall cycle counter (zero unless FETCH_CTL_PERF_EN)
module fetch_ctl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned IMEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_done,
    input  logic        hazard_stall,
    input  logic        dmem_stall,
    input  logic        br_ctl,
    input  logic        jump,
    input  logic        halt_dec,
    output logic        pc_en,
    output logic        imem_req,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        pipe_freeze,
    output logic        halted,
    output logic        err,
    output logic [15:0] stall_cnt
);

    localparam logic [2:0] S_BOOT    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_DISCARD = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_STOP    = 3'd5;

    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(IMEM_TIMEOUT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    logic [2:0]         state, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
    logic               err_nxt;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_BOOT;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            drain_cnt <= drain_nxt;
            err       <= err_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        pc_en       = 1'b0;
        imem_req    = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_freeze = 1'b0;
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        drain_nxt   = drain_cnt;
        err_nxt     = err;

        case (state)
            S_BOOT: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_FETCH, S_WAIT: begin
                imem_req = 1'b1;
                if_id_en = 1'b1;
                if (dmem_stall) begin
                    pipe_freeze = 1'b1;
                    if_id_en    = 1'b0;
                end else if (br_ctl || jump) begin
                    // Redirect; an outstanding fetch must be dropped when it lands
                    pc_en       = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = br_ctl;
                    if (!imem_done) begin
                        state_nxt = S_DISCARD;
                    end else begin
                        state_nxt = S_FETCH;
                        wait_nxt  = '0;
                    end
                end else if (halt_dec) begin
                    if_id_flush = 1'b1;
                    state_nxt   = S_DRAIN;
                    drain_nxt   = DRAIN_LOAD;
                    wait_nxt    = '0;
                end else if (hazard_stall) begin
                    // Hold IF/ID even if imem is also late
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    if (imem_done) begin
                        wait_nxt = '0;
                    end
                end else if (!imem_done) begin
                    if_id_flush = 1'b1;
                    if (state == S_WAIT && wait_cnt >= WAIT_LAST) begin
                        state_nxt = S_STOP;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        wait_nxt  = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    pc_en     = 1'b1;
                    state_nxt = S_FETCH;
                    wait_nxt  = '0;
                end
            end
            S_DISCARD: begin
                if_id_flush = 1'b1;
                if (imem_done) begin
                    state_nxt = S_FETCH;
                    wait_nxt  = '0;
                end else if (wait_cnt >= WAIT_LAST) begin
                    state_nxt = S_STOP;
                    err_nxt   = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            S_DRAIN: begin
                if_id_flush = 1'b1;
                // Drain only advances while the data side is moving
                if (!dmem_stall) begin
                    if (drain_cnt <= DRAIN_W'(1)) begin
                        drain_nxt = '0;
                        state_nxt = S_STOP;
                    end else begin
                        drain_nxt = drain_cnt - DRAIN_W'(1);
                    end
                end
            end
            S_STOP: begin
                state_nxt = S_STOP;
            end
            default: begin
                state_nxt = S_BOOT;
            end
        endcase
    end

    assign halted = (state == S_STOP);

`ifdef FETCH_CTL_PERF_EN
    logic [15:0] stall_q;

    // Saturating count of fetch-side cycles without a PC advance
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= 16'h0000;
        end else if ((state == S_FETCH || state == S_WAIT || state == S_DISCARD)
                     && !pc_en && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_ctl.sv
// Directed bench for fetch_ctl. Output vector order:
// {pc_en, imem_req, if_id_en, if_id_flush, id_ex_flush, pipe_freeze, halted, err}
module tb_fetch_ctl;

    logic        clk;
    logic        rst;
    logic        imem_done;
    logic        hazard_stall;
    logic        dmem_stall;
    logic        br_ctl;
    logic        jump;
    logic        halt_dec;
    logic        pc_en;
    logic        imem_req;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        pipe_freeze;
    logic        halted;
    logic        err;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    fetch_ctl #(
        .DRAIN_CYCLES(3),
        .IMEM_TIMEOUT(15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_done   (imem_done),
        .hazard_stall(hazard_stall),
        .dmem_stall  (dmem_stall),
        .br_ctl      (br_ctl),
        .jump        (jump),
        .halt_dec    (halt_dec),
        .pc_en       (pc_en),
        .imem_req    (imem_req),
        .if_id_en    (if_id_en),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .pipe_freeze (pipe_freeze),
        .halted      (halted),
        .err         (err),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] O_BOOT  = 8'b0001_1000;
    localparam logic [7:0] O_RUN   = 8'b1110_0000;
    localparam logic [7:0] O_IWAIT = 8'b0111_0000;
    localparam logic [7:0] O_FRZ   = 8'b0100_0100;
    localparam logic [7:0] O_BR    = 8'b1111_1000;
    localparam logic [7:0] O_JMP   = 8'b1111_0000;
    localparam logic [7:0] O_HAZ   = 8'b0100_1000;
    localparam logic [7:0] O_DISC  = 8'b0001_0000;
    localparam logic [7:0] O_HALT  = 8'b0111_0000;
    localparam logic [7:0] O_STOP  = 8'b0000_0010;
    localparam logic [7:0] O_TOUT  = 8'b0000_0011;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs {done, hazard, dmem, br, jump, halt} and let outputs settle
    task automatic set(input logic d, input logic hz, input logic dm,
                       input logic b, input logic j, input logic h);
        imem_done    = d;
        hazard_stall = hz;
        dmem_stall   = dm;
        br_ctl       = b;
        jump         = j;
        halt_dec     = h;
        #2;
    endtask

    task automatic chk(input string tag, input logic [7:0] expv);
        logic [7:0] obs;
        obs = {pc_en, imem_req, if_id_en, if_id_flush, id_ex_flush, pipe_freeze, halted, err};
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_stall(input string tag, input int unsigned n);
        logic [15:0] expv;
`ifdef FETCH_CTL_PERF_EN
        expv = 16'(n);
`else
        expv = 16'h0000;
        if (n > 32'd0) expv = 16'h0000;
`endif
        total++;
        assert (stall_cnt === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, stall_cnt, expv);
        end
    endtask

    initial begin
        rst = 1'b0;
        set(0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // Reset and boot
        set(1, 0, 0, 0, 0, 0);
        chk("reset_boot", O_BOOT);
        chk_stall("reset_stall", 0);
        rst = 1'b1;
        set(1, 0, 0, 0, 0, 0);
        chk("boot", O_BOOT);
        tick();
        chk("fetch0", O_RUN);
        tick();
        chk("fetch1", O_RUN);
        tick();

        // Three imem wait cycles then resume
        set(0, 0, 0, 0, 0, 0);
        chk("iwait1", O_IWAIT);
        tick();
        chk("iwait2", O_IWAIT);
        tick();
        chk("iwait3", O_IWAIT);
        tick();
        set(1, 0, 0, 0, 0, 0);
        chk("iwait_done", O_RUN);
        tick();

        // dmem freeze beats branch, then branch takes effect
        set(1, 0, 1, 1, 0, 0);
        chk("freeze_over_br", O_FRZ);
        tick();
        set(1, 0, 0, 1, 0, 0);
        chk("br_after_freeze", O_BR);
        tick();

        // hazard hold beats imem bubble
        set(0, 1, 0, 0, 0, 0);
        chk("hazard_over_imem", O_HAZ);
        tick();

        // Branch while waiting, then discard the late fetch
        set(0, 0, 0, 0, 0, 0);
        chk("pre_br_wait", O_IWAIT);
        tick();
        set(0, 0, 0, 1, 0, 0);
        chk("br_in_wait", O_BR);
        tick();
        set(0, 0, 0, 0, 1, 0);
        chk("discard_wait", O_DISC);
        tick();
        set(1, 0, 0, 1, 0, 0);
        chk("discard_drop", O_DISC);
        tick();
        set(1, 0, 0, 0, 0, 0);
        chk("after_discard", O_RUN);
        tick();

        // Jump with fetch already back: no ID/EX bubble
        set(1, 0, 0, 0, 1, 0);
        chk("jump", O_JMP);
        tick();

        // Halt with one frozen drain cycle: halted 4 cycles later
        set(1, 0, 0, 0, 0, 1);
        chk("halt_dec", O_HALT);
        tick();
        set(1, 0, 1, 0, 0, 0);
        chk("drain1_frozen", O_DISC);
        tick();
        set(1, 0, 0, 1, 0, 0);
        chk("drain2", O_DISC);
        tick();
        set(1, 0, 0, 0, 1, 0);
        chk("drain3", O_DISC);
        tick();
        set(1, 0, 0, 0, 0, 0);
        chk("stopped", O_STOP);
        chk_stall("stall_at_halt", 9);
        tick();
        set(1, 0, 0, 1, 1, 0);
        chk("stop_sticky", O_STOP);
        tick();

        // Reset from STOP
        rst = 1'b0;
        set(1, 0, 0, 0, 0, 0);
        tick();
        chk("rst_from_stop", O_BOOT);
        chk_stall("stall_cleared", 0);
        rst = 1'b1;
        tick();
        chk("fetch_after_rst", O_RUN);
        tick();

        // Reset in the middle of DISCARD
        set(0, 0, 0, 1, 0, 0);
        chk("br_to_discard", O_BR);
        tick();
        set(0, 0, 0, 0, 0, 0);
        chk("in_discard", O_DISC);
        rst = 1'b0;
        tick();
        chk("rst_from_discard", O_BOOT);
        rst = 1'b1;
        tick();
        set(1, 0, 0, 0, 0, 0);
        chk("fetch_after_rst2", O_RUN);
        tick();

        // Timeout: 15 wait cycles then err + halted
        set(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            chk($sformatf("tout_wait%0d", i), O_IWAIT);
            tick();
        end
        chk("timeout", O_TOUT);
        chk_stall("stall_at_timeout", 15);
        tick();
        set(1, 0, 0, 0, 0, 0);
        chk("timeout_sticky", O_TOUT);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
